// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns, COLS_PER_CYCLE columns per busy cycle.
// Optional MIXCOL_LAST_ROUND_EN adds i_bypass (captured 1 passes the state through).
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_inv,
`ifdef MIXCOL_LAST_ROUND_EN
    input  logic         i_bypass,
`endif
    input  logic [127:0] i_state,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_state
);

    localparam int N = 4 / COLS_PER_CYCLE;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $fatal(1, "COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [127:0]  src_q, src_d;
    logic [127:0]  out_q, out_d;
    logic          inv_q, inv_d;
    logic          byp_q, byp_d;
    logic          byp_in;
    logic          accept;
    logic          last;
    logic [127:0]  wrk;

`ifdef MIXCOL_LAST_ROUND_EN
    assign byp_in = i_bypass;
`else
    assign byp_in = 1'b0;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] a;
        p = 8'h00;
        a = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    // Row r uses the coefficient row rotated right by r.
    function automatic logic [31:0] mixcol(input logic [31:0] col, input logic inv);
        logic [3:0]  m [4];
        logic [7:0]  a [4];
        logic [31:0] r;
        if (inv) m = '{4'he, 4'hb, 4'hd, 4'h9};
        else     m = '{4'h2, 4'h3, 4'h1, 4'h1};
        for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = gm(a[0], m[(4-i)%4]) ^ gm(a[1], m[(5-i)%4])
                           ^ gm(a[2], m[(6-i)%4]) ^ gm(a[3], m[(7-i)%4]);
        end
        return r;
    endfunction

    assign o_ready = (state_q == IDLE) || ((state_q == DONE) && i_ready);
    assign accept  = i_valid && o_ready;
    assign last    = (cnt_q == 2'(N - 1));
    assign o_valid = (state_q == DONE);
    assign o_state = out_q;

    always_comb begin
        wrk = src_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            int c;
            c = int'(cnt_q) * COLS_PER_CYCLE + k;
            wrk[32*c +: 32] = byp_q ? src_q[32*c +: 32] : mixcol(src_q[32*c +: 32], inv_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        out_d   = out_q;
        inv_d   = inv_q;
        byp_d   = byp_q;
        unique case (state_q)
            BUSY: begin
                src_d = wrk;
                cnt_d = cnt_q + 2'd1;
                if (last) begin
                    out_d   = wrk;
                    cnt_d   = 2'd0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            src_d   = i_state;
            inv_d   = i_inv;
            byp_d   = byp_in;
            cnt_d   = 2'd0;
            state_d = BUSY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            src_q   <= '0;
            out_q   <= '0;
            inv_q   <= 1'b0;
            byp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            out_q   <= out_d;
            inv_q   <= inv_d;
            byp_q   <= byp_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2 and 4 in parallel.
// Expected results come from a GF(2^8) matrix model using polynomial reduction.
module tb_mix_columns_iter;

    logic clk;
    int   vectors = 0;
    int   miscompares = 0;
    int   fin_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int d = 15; d >= 8; d--)
            if (p[d]) p = p ^ (16'h011b << (d - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(base[(j - r + 4) % 4], s[32*c+31-8*j -: 8]);
                res[32*c+31-8*r -: 8] = acc;
            end
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input int id, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cpc=%0d got %h want %h", nm, id, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int CPC = 1 << g;
        localparam int N = 4 / CPC;

        logic         rst_n, valid, inv, rdy, byp, rnd_rdy;
        logic         ordy, ovalid;
        logic [127:0] st, ostate;
        logic [127:0] q [$];

        mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_valid (valid),
            .o_ready (ordy),
            .i_inv   (inv),
`ifdef MIXCOL_LAST_ROUND_EN
            .i_bypass(byp),
`endif
            .i_state (st),
            .o_valid (ovalid),
            .i_ready (rdy),
            .o_state (ostate)
        );

        always @(negedge clk) begin
            if (rst_n && ovalid && rdy) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious cpc=%0d got %h want none", CPC, ostate);
                end else begin
                    chk("result", CPC, ostate, q.pop_front());
                end
            end
        end

        always @(posedge clk) begin
            if (rnd_rdy) begin
                #1;
                if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
            end
        end

        // Called at posedge+1; returns at accept edge+1 with t = negedges waited.
        task automatic do_accept(input logic [127:0] s, input logic iv,
                                 input logic [127:0] exp, input bit push,
                                 output int t);
            valid = 1'b1;
            st    = s;
            inv   = iv;
            t     = 0;
            @(negedge clk);
            while (!ordy && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!ordy) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout cpc=%0d got ready=0 want 1", CPC);
            end else if (push) begin
                q.push_back(exp);
            end
            @(posedge clk);
            #1;
            valid = 1'b0;
            st    = rnd128();
            inv   = 1'($urandom);
        endtask

        task automatic wait_valid(output int k);
            k = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
            end while (!ovalid && k < 40);
        endtask

        initial begin
            int t, k;
            logic [127:0] x, hold, e;
            logic iv;
            rst_n = 1'b0; valid = 1'b0; inv = 1'b0; rdy = 1'b0;
            byp = 1'b0; rnd_rdy = 1'b0; st = rnd128();
            repeat (3) @(posedge clk);
            #1;
            chk("rst_valid", CPC, 128'(ovalid), 128'(0));
            chk("rst_state", CPC, ostate, 128'h0);
            chk("rst_ready", CPC, 128'(ordy), 128'(1));
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("ready_after_rst", CPC, 128'(ordy), 128'(1));

            rdy = 1'b1;
            do_accept(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                      128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1, t);
            wait_valid(k);
            chk("fwd_latency", CPC, 128'(k), 128'(N));
            @(posedge clk);
            #1;
            do_accept(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
                      128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 1, t);
            wait_valid(k);
            chk("inv_latency", CPC, 128'(k), 128'(N));
            @(posedge clk);
            #1;

            rdy = 1'b0;
            x = rnd128();
            do_accept(x, 1'b0, ref_mix(x, 1'b0), 1, t);
            wait_valid(k);
            chk("bp_latency", CPC, 128'(k), 128'(N));
            hold = ostate;
            for (int i = 0; i < 5; i++) begin
                valid = 1'($urandom);
                st = rnd128();
                @(posedge clk);
                #1;
                chk("bp_valid", CPC, 128'(ovalid), 128'(1));
                chk("bp_state", CPC, ostate, hold);
                chk("bp_ready", CPC, 128'(ordy), 128'(0));
            end
            rdy = 1'b1;
            x = rnd128();
            do_accept(x, 1'b1, ref_mix(x, 1'b1), 1, t);
            chk("b2b_same_edge", CPC, 128'(t), 128'(0));
            wait_valid(k);
            chk("b2b_latency", CPC, 128'(k), 128'(N));
            @(posedge clk);
            #1;

            rdy = 1'b0;
            do_accept(rnd128(), 1'b0, 128'h0, 0, t);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst_valid", CPC, 128'(ovalid), 128'(0));
            chk("midrst_state", CPC, ostate, 128'h0);
            chk("midrst_ready", CPC, 128'(ordy), 128'(1));
            rst_n = 1'b1;
            rdy = 1'b1;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                chk("no_stale", CPC, 128'(ovalid), 128'(0));
            end

`ifdef MIXCOL_LAST_ROUND_EN
            byp = 1'b1;
            do_accept(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0,
                      128'h00112233_44556677_8899aabb_ccddeeff, 1, t);
            wait_valid(k);
            chk("byp_latency", CPC, 128'(k), 128'(N));
            byp = 1'b0;
            @(posedge clk);
            #1;
`endif

            rnd_rdy = 1'b1;
            for (int b = 0; b < 1000; b++) begin
                x = rnd128();
                iv = 1'($urandom);
`ifdef MIXCOL_LAST_ROUND_EN
                byp = ($urandom_range(0, 7) == 0);
`endif
                if (b % 4 == 3 && !byp) begin
                    do_accept(ref_mix(x, 1'b0), 1'b1, x, 1, t);
                end else begin
                    e = byp ? x : ref_mix(x, iv);
                    do_accept(x, iv, e, 1, t);
                end
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            byp = 1'b0;
            rnd_rdy = 1'b0;
            #2;
            rdy = 1'b1;
            k = 0;
            while (q.size() != 0 && k < 30) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("drain_empty", CPC, 128'(q.size()), 128'(0));
            fin_cnt++;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (fin_cnt < 3 && cyc < 90000) begin
            @(posedge clk);
            cyc++;
        end
        if (fin_cnt < 3) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout got %0d finished want 3", fin_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
